// File: rtl/conv_bcd_signo.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with sign flag.
// Optional macro BCD_SIGNED_EN: treat Bin as two's complement and convert its magnitude.
module conv_bcd_signo #(
    parameter int tamanyo = 32,
    parameter int DIGITOS = 10
) (
    input  logic                   CLK,
    input  logic                   RSTa,
    input  logic                   Start,
    input  logic [tamanyo-1:0]     Bin,
    output logic [4*DIGITOS-1:0]   BCD,
    output logic                   Signo,
    output logic                   Done,
    output logic                   Busy
);

    localparam int AW = 4 * DIGITOS;
    localparam int CW = $clog2(tamanyo + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, END} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [tamanyo-1:0] mag_q, mag_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [AW-1:0]      bcd_q, bcd_d;
    logic               signo_q, signo_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               negIn;
    logic [tamanyo-1:0] magIn;
    logic [AW-1:0]      accAdj;
    logic [AW-1:0]      accShift;
    logic [tamanyo-1:0] magShift;

`ifdef BCD_SIGNED_EN
    // Negating the most-negative value wraps to 2^(tamanyo-1), which is the correct unsigned magnitude.
    assign negIn = Bin[tamanyo-1];
    assign magIn = negIn ? (~Bin + tamanyo'(1)) : Bin;
`else
    assign negIn = 1'b0;
    assign magIn = Bin;
`endif

    always_comb begin
        accAdj = acc_q;
        for (int i = 0; i < DIGITOS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                accAdj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign accShift = {accAdj[AW-2:0], mag_q[tamanyo-1]};
    assign magShift = {mag_q[tamanyo-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        signo_d = signo_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    mag_d   = magIn;
                    sign_d  = negIn;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = accShift;
                mag_d = magShift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(tamanyo - 1)) begin
                    state_d = END;
                end
            end
            END: begin
                bcd_d   = acc_q;
                signo_d = sign_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            signo_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            signo_q <= signo_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign BCD   = bcd_q;
    assign Signo = signo_q;
    assign Done  = done_q;
    assign Busy  = busy_q;

endmodule

// File: tb/tb_conv_bcd_signo.sv
// Table-driven bench for conv_bcd_signo plus directed sequences for Start-ignore, back-to-back and reset.
module tb_conv_bcd_signo;

    logic        CLK = 1'b0;
    logic        RSTa = 1'b0;
    logic        Start = 1'b0;
    logic [31:0] Bin = '0;
    logic [39:0] BCD;
    logic        Signo;
    logic        Done;
    logic        Busy;

    int checks = 0;
    int failures = 0;

    conv_bcd_signo #(.tamanyo(32), .DIGITOS(10)) dut (
        .CLK(CLK), .RSTa(RSTa), .Start(Start), .Bin(Bin),
        .BCD(BCD), .Signo(Signo), .Done(Done), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] bin;
        logic [39:0] expBcd;
        logic        expSigno;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts one conversion and waits for Done; lat is -1 if Done never arrives.
    task automatic applyStimulus(input logic [31:0] b, output logic [39:0] bcd, output logic s,
                                 output int lat, output int busyCnt);
        @(negedge CLK);
        Start = 1'b1;
        Bin = b;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        lat = 0;
        busyCnt = Busy ? 1 : 0;
        while (!Done && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
            if (Busy) busyCnt++;
        end
        if (!Done) lat = -1;
        bcd = BCD;
        s = Signo;
    endtask

    logic [39:0] rBcd;
    logic        rSig;
    int          lat;
    int          busyCnt;
    int          doneCnt;
    int          gap;

    initial begin
        vecs[0] = '{32'd0,          40'h0000000000, 1'b0};
        vecs[1] = '{32'd1234567,    40'h0001234567, 1'b0};
        vecs[2] = '{32'd10,         40'h0000000010, 1'b0};
        vecs[3] = '{32'd99999,      40'h0000099999, 1'b0};
        vecs[4] = '{32'h7FFFFFFF,   40'h2147483647, 1'b0};
`ifdef BCD_SIGNED_EN
        vecs[5] = '{32'hFFFFFFFF,   40'h0000000001, 1'b1};
        vecs[6] = '{32'hFFFFFF01,   40'h0000000255, 1'b1};
        vecs[7] = '{32'h80000000,   40'h2147483648, 1'b1};
`else
        vecs[5] = '{32'hFFFFFFFF,   40'h4294967295, 1'b0};
        vecs[6] = '{32'hFFFFFF01,   40'h4294967041, 1'b0};
        vecs[7] = '{32'h80000000,   40'h2147483648, 1'b0};
`endif
        vecs[8] = '{32'd42,         40'h0000000042, 1'b0};

        #1;
        checkOutput("reset_outputs", {BCD, Signo, Done, Busy}, 64'd0);
        #20;
        @(negedge CLK);
        RSTa = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].bin, rBcd, rSig, lat, busyCnt);
            checkOutput($sformatf("latency[%0d]", i), 64'(lat), 64'd33);
            checkOutput($sformatf("bcd[%0d]", i), 64'(rBcd), 64'(vecs[i].expBcd));
            checkOutput($sformatf("signo[%0d]", i), 64'(rSig), 64'(vecs[i].expSigno));
            checkOutput($sformatf("busy_cycles[%0d]", i), 64'(busyCnt), 64'd33);
            checkOutput($sformatf("busy_low_at_done[%0d]", i), 64'(Busy), 64'd0);
            @(posedge CLK);
            #1;
            checkOutput($sformatf("done_pulse_width[%0d]", i), 64'(Done), 64'd0);
            checkOutput($sformatf("bcd_hold[%0d]", i), 64'(BCD), 64'(vecs[i].expBcd));
        end

        // Second Start mid-conversion must be ignored; BCD holds the old result while shifting.
        @(negedge CLK);
        Start = 1'b1;
        Bin = 32'd42;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        Bin = 32'd12345;
        doneCnt = 0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge CLK);
            #1;
            if (Done) doneCnt++;
            if (c == 5) begin
                checkOutput("bcd_stable_in_shift", 64'(BCD), 64'h0000000042);
                Start = 1'b1;
                Bin = 32'd99;
            end else begin
                Start = 1'b0;
            end
        end
        checkOutput("ignored_start_done_count", 64'(doneCnt), 64'd1);
        checkOutput("ignored_start_bcd", 64'(BCD), 64'h0000000042);

        // Start held high: Done pulses every tamanyo+2 cycles.
        @(negedge CLK);
        Start = 1'b1;
        Bin = 32'd5;
        gap = 0;
        doneCnt = 0;
        for (int c = 0; c < 120 && doneCnt < 2; c++) begin
            @(posedge CLK);
            #1;
            if (doneCnt == 1) gap++;
            if (Done) doneCnt++;
        end
        Start = 1'b0;
        checkOutput("b2b_done_count", 64'(doneCnt), 64'd2);
        checkOutput("b2b_gap", 64'(gap), 64'd34);
        checkOutput("b2b_bcd", 64'(BCD), 64'h0000000005);
        repeat (40) @(posedge CLK);
        #1;

        // Asynchronous reset in the middle of a conversion.
        @(negedge CLK);
        Start = 1'b1;
        Bin = 32'd31337;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        RSTa = 1'b0;
        #1;
        checkOutput("midreset_outputs", {BCD, Signo, Done, Busy}, 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RSTa = 1'b1;
        doneCnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK);
            #1;
            if (Done || Busy) doneCnt++;
        end
        checkOutput("midreset_no_done", 64'(doneCnt), 64'd0);
        applyStimulus(32'd7, rBcd, rSig, lat, busyCnt);
        checkOutput("after_reset_latency", 64'(lat), 64'd33);
        checkOutput("after_reset_bcd", 64'(rBcd), 64'h0000000007);
        checkOutput("after_reset_signo", 64'(rSig), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
